// File: rtl/vend_pkg.sv
// Shared types, widths, coin decode and the per-channel price table for
// the vending channel scheduler.
package vend_pkg;

  localparam int NCH = 7;   // channels, numbered 1..NCH
  localparam int CW  = 3;   // stock width per channel
  localparam int MW  = 7;   // money width, in coin units

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SUPPLY   = 3'd1,
    ST_PAY      = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_CHANGE   = 3'd4
  } state_e;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_BAD   = 2'b01;
  localparam logic [1:0] ERR_SHORT = 2'b10;
  localparam logic [1:0] ERR_SAT   = 2'b11;

  function automatic logic [MW-1:0] coin_units(input logic [1:0] code);
    case (code)
      2'b00:   coin_units = MW'(1);
      2'b01:   coin_units = MW'(2);
      2'b10:   coin_units = MW'(5);
      default: coin_units = MW'(10);
    endcase
  endfunction

  // Channel 0 does not exist; it prices at 0 but is rejected before use.
  function automatic logic [MW-1:0] price_of(input logic [2:0] num);
    case (num)
      3'd1:    price_of = MW'(2);
      3'd2:    price_of = MW'(3);
      3'd3:    price_of = MW'(3);
      3'd4:    price_of = MW'(4);
      3'd5:    price_of = MW'(5);
      3'd6:    price_of = MW'(6);
      3'd7:    price_of = MW'(8);
      default: price_of = '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-channel stock registers with one shared address, a saturating add
// port and a decrement port; the scheduler never enables both at once.
module vend_stock_bank
  import vend_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        num,
  input  logic              add_en,
  input  logic [CW-1:0]     add_cnt,
  input  logic              dec_en,
  output logic [CW-1:0]     rd_data,
  output logic              add_sat,
  output logic [NCH*CW-1:0] stock_flat
);

  // Packed so that channel k lands at [k*CW-1 -: CW] of the flat view.
  logic [NCH:1][CW-1:0] stk_q, stk_d;
  logic [CW:0]          sum;

  always_comb begin
    rd_data = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (num == 3'(k)) rd_data = stk_q[k];
    end
  end

  assign sum     = {1'b0, rd_data} + {1'b0, add_cnt};
  assign add_sat = sum[CW];

  always_comb begin
    stk_d = stk_q;
    for (int k = 1; k <= NCH; k++) begin
      if (num == 3'(k)) begin
        if (add_en)      stk_d[k] = add_sat ? '1 : sum[CW-1:0];
        else if (dec_en) stk_d[k] = stk_q[k] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stk_q <= '0;
    else          stk_q <= stk_d;
  end

  assign stock_flat = stk_q;

endmodule

// File: rtl/vend_channel_sched.sv
// Vending channel scheduler: one restock or purchase at a time, coin
// collection, paced dispense pulses and a single change pulse per purchase.
module vend_channel_sched
  import vend_pkg::*;
#(
  parameter int DISP_GAP = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              supply,
  input  logic [2:0]        op_num,
  input  logic [2:0]        op_count,
  input  logic              coin_valid,
  input  logic [1:0]        coin_val,
  input  logic              cancel,
  output logic [NCH*CW-1:0] stock,
  output logic [MW-1:0]     paid,
  output logic              dispense,
  output logic [2:0]        disp_num,
  output logic              change_valid,
  output logic [MW-1:0]     change_amt,
  output logic [1:0]        err,
  output state_e            dbg_state
);

  localparam int GW = (DISP_GAP > 2) ? $clog2(DISP_GAP) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST = GW'(DISP_GAP - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  // Handshake: an operation is taken on any rising edge where
  // op_valid && op_ready; op_ready is high exactly while the FSM is IDLE.
  state_e          state_q, state_d;
  logic [2:0]      num_q, num_d;
  logic [CW-1:0]   count_q, count_d;
  logic [MW-1:0]   cost_q, cost_d;
  logic [MW-1:0]   paid_q, paid_d;
  logic [1:0]      err_q, err_d;
  logic [MW-1:0]   chg_q, chg_d;
  logic [2:0]      disp_num_q, disp_num_d;
  logic [CW-1:0]   left_q, left_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic            add_en, dec_en, add_sat;
  logic [2:0]      bank_num;
  logic [CW-1:0]   rd_data;
  logic [MW-1:0]   paid_pay;

  assign bank_num = (state_q == ST_IDLE) ? op_num : num_q;
  assign paid_pay = paid_q + (coin_valid ? coin_units(coin_val) : '0);

  vend_stock_bank u_bank (
    .clk        (clk),
    .reset_n    (reset_n),
    .num        (bank_num),
    .add_en     (add_en),
    .add_cnt    (count_q),
    .dec_en     (dec_en),
    .rd_data    (rd_data),
    .add_sat    (add_sat),
    .stock_flat (stock)
  );

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    count_d    = count_q;
    cost_d     = cost_q;
    paid_d     = paid_q;
    err_d      = err_q;
    chg_d      = chg_q;
    disp_num_d = disp_num_q;
    left_d     = left_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    add_en     = 1'b0;
    dec_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          num_d   = op_num;
          count_d = op_count;
          err_d   = ERR_OK;
          if (op_num == 3'd0 || op_count == 3'd0) begin
            err_d = ERR_BAD;
          end else if (supply) begin
            state_d = ST_SUPPLY;
          end else if (op_count > rd_data) begin
            err_d = ERR_SHORT;
          end else begin
            cost_d  = price_of(op_num) * MW'(op_count);
            paid_d  = '0;
            tmo_d   = '0;
            state_d = ST_PAY;
          end
        end
      end
      ST_SUPPLY: begin
        add_en  = 1'b1;
        err_d   = add_sat ? ERR_SAT : ERR_OK;
        state_d = ST_IDLE;
      end
      ST_PAY: begin
        paid_d = paid_pay;
        tmo_d  = coin_valid ? '0 : tmo_q + TW'(1);
        // A coin arriving with cancel is part of the refund.
        if (cancel || (!coin_valid && tmo_q == TMO_LAST)) begin
          chg_d   = paid_pay;
          state_d = ST_CHANGE;
        end else if (paid_q >= cost_q) begin
          gap_d      = '0;
          left_d     = count_q;
          disp_num_d = num_q;
          state_d    = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        if (gap_q == '0) begin
          dec_en = 1'b1;
          gap_d  = GAP_LAST;
          left_d = left_q - CW'(1);
          if (left_q == CW'(1)) begin
            chg_d   = paid_q - cost_q;
            state_d = ST_CHANGE;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      ST_CHANGE: begin
        paid_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      count_q    <= '0;
      cost_q     <= '0;
      paid_q     <= '0;
      err_q      <= ERR_OK;
      chg_q      <= '0;
      disp_num_q <= '0;
      left_q     <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      count_q    <= count_d;
      cost_q     <= cost_d;
      paid_q     <= paid_d;
      err_q      <= err_d;
      chg_q      <= chg_d;
      disp_num_q <= disp_num_d;
      left_q     <= left_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
    end
  end

  assign op_ready     = (state_q == ST_IDLE);
  assign dispense     = (state_q == ST_DISPENSE) && (gap_q == '0);
  assign change_valid = (state_q == ST_CHANGE);
  assign paid         = paid_q;
  assign err          = err_q;
  assign change_amt   = chg_q;
  assign disp_num     = disp_num_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_vend_channel_sched.sv
// Directed bench for vend_channel_sched: restock, purchase, rejects,
// cancel, timeout and reset during dispense against hand-computed values.
module tb_vend_channel_sched;
  import vend_pkg::*;

  localparam int TMO = 1000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic              supply = 1'b0;
  logic [2:0]        op_num = '0;
  logic [2:0]        op_count = '0;
  logic              coin_valid = 1'b0;
  logic [1:0]        coin_val = '0;
  logic              cancel = 1'b0;
  logic [NCH*CW-1:0] stock;
  logic [MW-1:0]     paid;
  logic              dispense;
  logic [2:0]        disp_num;
  logic              change_valid;
  logic [MW-1:0]     change_amt;
  logic [1:0]        err;
  state_e            dbg_state;

  int checks = 0;
  int errors = 0;
  int npulse, first_i, second_i;
  bit got_chg, saw_chg;
  logic [MW-1:0] amt;

  vend_channel_sched #(.DISP_GAP(4), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .supply       (supply),
    .op_num       (op_num),
    .op_count     (op_count),
    .coin_valid   (coin_valid),
    .coin_val     (coin_val),
    .cancel       (cancel),
    .stock        (stock),
    .paid         (paid),
    .dispense     (dispense),
    .disp_num     (disp_num),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] stk3(input int c1, input int c2, input int c3);
    stk3 = 32'(c1) | (32'(c2) << 3) | (32'(c3) << 6);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic s, input logic [2:0] n, input logic [2:0] c);
    op_valid = 1'b1; supply = s; op_num = n; op_count = c;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic put_coin(input logic [1:0] v, input logic canc);
    coin_valid = 1'b1; coin_val = v; cancel = canc;
    tick();
    coin_valid = 1'b0; cancel = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst_ready", 32'(op_ready), 1);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_stock", 32'(stock), 0);
    chk("rst_paid", 32'(paid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_chg", 32'(change_amt), 0);
    chk("rst_dnum", 32'(disp_num), 0);
    chk("rst_pulses", 32'({dispense, change_valid}), 0);

    // Restock ch3 by 5, then by 4 (saturates)
    do_op(1'b1, 3'd3, 3'd5);
    chk("sup_state", 32'(dbg_state), 32'(ST_SUPPLY));
    chk("sup_ready", 32'(op_ready), 0);
    tick();
    chk("sup1_stock", 32'(stock), stk3(0, 0, 5));
    chk("sup1_err", 32'(err), 0);
    do_op(1'b1, 3'd3, 3'd4);
    tick();
    chk("sup2_stock", 32'(stock), stk3(0, 0, 7));
    chk("sup2_err", 32'(err), 3);
    do_op(1'b1, 3'd2, 3'd3);
    tick();
    chk("sup3_err", 32'(err), 0);
    do_op(1'b1, 3'd1, 3'd2);
    tick();
    chk("sup4_stock", 32'(stock), stk3(2, 3, 7));

    // Short stock: ch1 x3 with 2 in stock
    do_op(1'b0, 3'd1, 3'd3);
    chk("short_err", 32'(err), 2);
    chk("short_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("short_ready", 32'(op_ready), 1);
    repeat (3) begin
      chk("short_nopulse", 32'({dispense, change_valid}), 0);
      tick();
    end
    chk("short_stock", 32'(stock), stk3(2, 3, 7));

    // Bad num / bad count
    do_op(1'b0, 3'd0, 3'd3);
    chk("bad_num_err", 32'(err), 1);
    chk("bad_num_state", 32'(dbg_state), 32'(ST_IDLE));
    do_op(1'b1, 3'd5, 3'd0);
    chk("bad_cnt_err", 32'(err), 1);
    chk("bad_cnt_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("bad_stock", 32'(stock), stk3(2, 3, 7));

    // Purchase ch2 x2, cost 6, coins 5 then 2
    do_op(1'b0, 3'd2, 3'd2);
    chk("buy_state", 32'(dbg_state), 32'(ST_PAY));
    chk("buy_err", 32'(err), 0);
    put_coin(2'b10, 1'b0);
    chk("buy_paid5", 32'(paid), 5);
    put_coin(2'b01, 1'b0);
    chk("buy_paid7", 32'(paid), 7);
    chk("buy_still_pay", 32'(dbg_state), 32'(ST_PAY));
    tick();
    npulse = 0; first_i = -1; second_i = -1; got_chg = 0; amt = '0;
    for (int i = 0; i < 40 && !got_chg; i++) begin
      if (dispense) begin
        chk("buy_dnum", 32'(disp_num), 2);
        if (npulse == 0) first_i = i; else second_i = i;
        npulse++;
      end
      if (change_valid) begin
        got_chg = 1;
        amt = change_amt;
      end else begin
        tick();
      end
    end
    chk("buy_first", 32'(first_i), 0);
    chk("buy_npulse", 32'(npulse), 2);
    chk("buy_gap", 32'(second_i - first_i), 4);
    chk("buy_chg_seen", 32'(got_chg), 1);
    chk("buy_chg_amt", 32'(amt), 1);
    chk("buy_stock", 32'(stock), stk3(2, 1, 7));
    tick();
    chk("buy_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("buy_paid0", 32'(paid), 0);

    // Cancel with coin in the same cycle: ch3 x2, cost 6
    do_op(1'b0, 3'd3, 3'd2);
    put_coin(2'b01, 1'b0);
    put_coin(2'b00, 1'b1);
    chk("can_chg_v", 32'(change_valid), 1);
    chk("can_chg_amt", 32'(change_amt), 3);
    tick();
    chk("can_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("can_stock", 32'(stock), stk3(2, 1, 7));

    // Timeout: refund arrives exactly TMO cycles after the last coin
    do_op(1'b0, 3'd3, 3'd2);
    put_coin(2'b01, 1'b0);
    put_coin(2'b00, 1'b0);
    repeat (TMO - 1) tick();
    chk("tmo_pending", 32'(dbg_state), 32'(ST_PAY));
    tick();
    chk("tmo_chg_v", 32'(change_valid), 1);
    chk("tmo_chg_amt", 32'(change_amt), 3);
    tick();
    chk("tmo_stock", 32'(stock), stk3(2, 1, 7));

    // Reset in the middle of DISPENSE: ch3 x1, cost 3, coin 5
    do_op(1'b0, 3'd3, 3'd1);
    put_coin(2'b10, 1'b0);
    tick();
    chk("rd_in_disp", 32'(dispense), 1);
    reset_n = 1'b0;
    #1;
    chk("rd_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rd_stock", 32'(stock), 0);
    chk("rd_paid", 32'(paid), 0);
    chk("rd_pulses", 32'({dispense, change_valid}), 0);
    chk("rd_dnum", 32'(disp_num), 0);
    saw_chg = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (change_valid) saw_chg = 1;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      tick();
      if (change_valid) saw_chg = 1;
    end
    chk("rd_no_chg", 32'(saw_chg), 0);
    chk("rd_ready", 32'(op_ready), 1);
    chk("rd_stock_after", 32'(stock), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
